// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, optional parity, 1/2 stop bits,
// 3-sample majority voting, per-frame error/break flags and gap-based idle/eop.
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ     = 12000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned OVERSAMPLING = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned GAP_BITS     = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_idle,
  output logic                 rx_eop
);

  localparam int unsigned INC     = BAUD * OVERSAMPLING;
  localparam int          OS_W    = $clog2(OVERSAMPLING);
  localparam int unsigned GAP_MAX = GAP_BITS * OVERSAMPLING;
  localparam int          GAP_W   = $clog2(GAP_MAX + 1);

  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLING / 2);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLING - 1);
  localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(GAP_MAX);
  localparam logic [GAP_W-1:0] GAP_PRE  = GAP_W'(GAP_MAX - 1);
  localparam logic [3:0]       DB_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]       SB_LAST  = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  // Phase accumulator: exact average tick rate, never realigned to the line.
  logic [31:0] acc;
  logic [32:0] acc_sum;
  logic        os_tick;

  assign acc_sum = {1'b0, acc} + 33'(INC);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc     <= '0;
      os_tick <= 1'b0;
    end else if (acc_sum >= 33'(CLK_FREQ)) begin
      acc     <= 32'(acc_sum - 33'(CLK_FREQ));
      os_tick <= 1'b1;
    end else begin
      acc     <= acc_sum[31:0];
      os_tick <= 1'b0;
    end
  end

  logic [1:0] sync;
  logic [2:0] hist;
  logic       rx_s;
  logic       maj;

  assign rx_s = sync[1];
  assign maj  = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync <= 2'b11;
      hist <= 3'b111;
    end else begin
      sync <= {sync[0], rx};
      if (os_tick) hist <= {hist[1:0], rx_s};
    end
  end

  state_t               state;
  logic [OS_W-1:0]      os_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] data_sr;
  logic                 par_bit;
  logic                 par_err;
  logic                 ferr_acc;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 frame_seen;
  logic                 at_sample;
  logic                 par_x;
  logic                 stop_fe;

  // The start bit is sampled mid-bit; every later bit exactly one bit-time on.
  assign at_sample = os_tick && ((state == S_START) ? (os_cnt == OS_MID) : (os_cnt == OS_LAST));
  assign par_x     = (^data_sr) ^ maj;
  assign stop_fe   = ferr_acc | ~maj;
  assign rx_idle   = (gap_cnt == GAP_FULL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      os_cnt        <= '0;
      bit_cnt       <= '0;
      data_sr       <= '0;
      par_bit       <= 1'b0;
      par_err       <= 1'b0;
      ferr_acc      <= 1'b0;
      gap_cnt       <= GAP_FULL;
      frame_seen    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      rx_eop        <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_break <= 1'b0;
      rx_eop   <= 1'b0;

      if (state != S_IDLE) gap_cnt <= '0;

      if (os_tick && state != S_IDLE && state != S_WAIT_HIGH)
        os_cnt <= at_sample ? '0 : os_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (os_tick) begin
            if (!rx_s) begin
              state   <= S_START;
              os_cnt  <= '0;
              gap_cnt <= '0;
            end else if (gap_cnt != GAP_FULL) begin
              gap_cnt <= gap_cnt + 1'b1;
              // eop only closes a packet that actually delivered a frame
              if (gap_cnt == GAP_PRE && frame_seen) begin
                rx_eop     <= 1'b1;
                frame_seen <= 1'b0;
              end
            end
          end
        end
        S_START: begin
          if (at_sample) begin
            if (maj) begin
              state <= S_IDLE;
            end else begin
              state    <= S_DATA;
              bit_cnt  <= '0;
              par_bit  <= 1'b0;
              par_err  <= 1'b0;
              ferr_acc <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (at_sample) begin
            data_sr <= {maj, data_sr[DATA_BITS-1:1]};
            if (bit_cnt == DB_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (at_sample) begin
            par_bit <= maj;
            par_err <= (PARITY == 1) ? par_x : ~par_x;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (at_sample) begin
            if (bit_cnt == SB_LAST) begin
              rx_valid      <= 1'b1;
              rx_data       <= data_sr;
              rx_parity_err <= par_err;
              rx_frame_err  <= stop_fe;
              rx_break      <= stop_fe && (data_sr == '0) && !par_bit;
              frame_seen    <= 1'b1;
              // A good frame returns mid-stop so back-to-back starts are caught.
              state         <= stop_fe ? S_WAIT_HIGH : S_IDLE;
            end else begin
              ferr_acc <= stop_fe;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (os_tick && maj) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomized self-checking bench: three receiver configurations on separate lines,
// each frame's expected outcome derived from the bits placed on the wire.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       rx_line [3];
  logic [7:0] a_data, b_data;
  logic [6:0] c_data;
  logic [2:0] valid, perr, ferr, brk, idle, eop;

  // Line configurations: 8N1 @16 clk/bit, 8E1 @32 clk/bit, 7O2 @64 clk/bit
  int dbits  [3] = '{8, 8, 7};
  int par    [3] = '{0, 1, 2};
  int nstop  [3] = '{1, 1, 2};
  int bitclk [3] = '{16, 32, 64};

  uart_rx_cfg #(.CLK_FREQ(16000000), .BAUD(1000000), .OVERSAMPLING(16), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .GAP_BITS(2)) u_a (
    .clk(clk), .resetn(resetn), .rx(rx_line[0]), .rx_data(a_data), .rx_valid(valid[0]),
    .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]), .rx_break(brk[0]),
    .rx_idle(idle[0]), .rx_eop(eop[0]));

  uart_rx_cfg #(.CLK_FREQ(16000000), .BAUD(500000), .OVERSAMPLING(8), .DATA_BITS(8),
                .PARITY(1), .STOP_BITS(1), .GAP_BITS(2)) u_b (
    .clk(clk), .resetn(resetn), .rx(rx_line[1]), .rx_data(b_data), .rx_valid(valid[1]),
    .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]), .rx_break(brk[1]),
    .rx_idle(idle[1]), .rx_eop(eop[1]));

  uart_rx_cfg #(.CLK_FREQ(16000000), .BAUD(250000), .OVERSAMPLING(32), .DATA_BITS(7),
                .PARITY(2), .STOP_BITS(2), .GAP_BITS(2)) u_c (
    .clk(clk), .resetn(resetn), .rx(rx_line[2]), .rx_data(c_data), .rx_valid(valid[2]),
    .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]), .rx_break(brk[2]),
    .rx_idle(idle[2]), .rx_eop(eop[2]));

  typedef struct {
    int         idx;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    int         cyc;
    int         lat_lo;
    int         lat_hi;
  } rec_t;

  rec_t       got_q[$];
  logic [8:0] data_w [3];
  int         cyc;
  int         eop_cnt [3];
  int         eop_cyc [3];
  int         last_valid_cyc [3];
  int         stray;
  int         n_checks;
  int         n_errors;

  assign data_w[0] = {1'b0, a_data};
  assign data_w[1] = {1'b0, b_data};
  assign data_w[2] = {2'b0, c_data};

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      eop_cnt[i] = 0;
      eop_cyc[i] = 0;
      last_valid_cyc[i] = 0;
    end
  end

  always @(negedge clk) begin
    rec_t r;
    for (int i = 0; i < 3; i++) begin
      if (valid[i]) begin
        r.idx = i; r.data = data_w[i]; r.perr = perr[i]; r.ferr = ferr[i];
        r.brk = brk[i]; r.cyc = cyc; r.lat_lo = 0; r.lat_hi = 0;
        got_q.push_back(r);
        last_valid_cyc[i] = cyc;
      end
      if (brk[i] && !valid[i]) stray++;
      if (eop[i]) begin
        eop_cnt[i]++;
        eop_cyc[i] = cyc;
        if (valid[i]) stray++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Valid should land half a bit into the final stop bit, give or take sampling skew.
  task automatic set_window(input int i, inout rec_t e);
    int ideal;
    ideal = (1 + dbits[i] + (par[i] != 0 ? 1 : 0) + nstop[i] - 1) * bitclk[i] + bitclk[i] / 2;
    e.lat_lo = ideal - 2;
    e.lat_hi = ideal + bitclk[i] / 2;
  endtask

  task automatic idle_bits(input int i, input int n);
    rx_line[i] = 1'b1;
    repeat (n * bitclk[i]) @(negedge clk);
  endtask

  task automatic send_frame(input int i, input logic [8:0] din, input logic flip_par,
                            input logic [1:0] stops, input int glitch, output rec_t e);
    logic [8:0] d;
    logic       pb;
    logic       seq [13];
    int         nb;
    d  = din & 9'((1 << dbits[i]) - 1);
    pb = (^d) ^ (par[i] == 2) ^ flip_par;
    nb = 0;
    seq[nb++] = 1'b0;
    for (int j = 0; j < dbits[i]; j++) seq[nb++] = d[j];
    if (par[i] != 0) seq[nb++] = pb;
    for (int j = 0; j < nstop[i]; j++) seq[nb++] = stops[j];
    e.idx  = i;
    e.data = d;
    e.perr = (par[i] != 0) && (($countones({d, pb}) % 2) != (par[i] == 2 ? 1 : 0));
    e.ferr = !stops[0] || (nstop[i] == 2 && !stops[1]);
    e.brk  = (d == 0) && (par[i] == 0 || !pb) && e.ferr;
    e.cyc  = cyc;
    set_window(i, e);
    for (int n = 0; n < nb; n++)
      for (int k = 0; k < bitclk[i]; k++) begin
        rx_line[i] = (n == glitch + 1 && k == bitclk[i] / 2) ? ~seq[n] : seq[n];
        @(negedge clk);
      end
    rx_line[i] = 1'b1;
  endtask

  task automatic expect_frame(input rec_t e);
    rec_t g;
    int   t;
    int   lat;
    t = 0;
    while (got_q.size() == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_eq("rx_valid_seen", 32'(got_q.size() != 0), 1);
    if (got_q.size() == 0) return;
    g = got_q.pop_front();
    lat = g.cyc - e.cyc;
    check_eq("line", g.idx, e.idx);
    check_eq($sformatf("rx_data[%0d]", e.idx), 32'(g.data), 32'(e.data));
    check_eq($sformatf("parity_err[%0d] data=%0h", e.idx, e.data), 32'(g.perr), 32'(e.perr));
    check_eq($sformatf("frame_err[%0d] data=%0h", e.idx, e.data), 32'(g.ferr), 32'(e.ferr));
    check_eq($sformatf("break[%0d] data=%0h", e.idx, e.data), 32'(g.brk), 32'(e.brk));
    check_eq($sformatf("latency[%0d]=%0d window %0d..%0d", e.idx, lat, e.lat_lo, e.lat_hi),
             32'(lat >= e.lat_lo && lat <= e.lat_hi), 1);
    $display("rx line=%0d data=%0h perr=%0b ferr=%0b brk=%0b latency=%0d",
             g.idx, g.data, g.perr, g.ferr, g.brk, lat);
  endtask

  initial begin
    rec_t e, e1, e2, e3;
    int   eop_before;
    int   li;
    n_checks = 0;
    n_errors = 0;
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) rx_line[i] = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("reset_data", {a_data, b_data, c_data}, 0);
    check_eq("reset_flags", {valid, perr, ferr, brk, eop}, 0);
    check_eq("reset_idle", 32'(idle), 32'h7);
    resetn = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("no_eop_after_reset", eop_cnt[0] + eop_cnt[1] + eop_cnt[2], 0);
    check_eq("idle_after_reset", 32'(idle), 32'h7);

    // 8N1 basic frame
    send_frame(0, 9'h0A5, 1'b0, 2'b11, -1, e); expect_frame(e); idle_bits(0, 3);

    // 8E1: good parity, then bad parity
    send_frame(1, 9'h003, 1'b0, 2'b11, -1, e); expect_frame(e); idle_bits(1, 2);
    send_frame(1, 9'h003, 1'b1, 2'b11, -1, e); expect_frame(e); idle_bits(1, 2);

    // 7O2 with second stop bit low, then a clean frame
    send_frame(2, 9'h041, 1'b0, 2'b01, -1, e); expect_frame(e); idle_bits(2, 2);
    send_frame(2, 9'h042, 1'b0, 2'b11, -1, e); expect_frame(e); idle_bits(2, 2);

    // Line held low for 40 bit-times: one break report only
    e.idx = 0; e.data = 0; e.perr = 0; e.ferr = 1; e.brk = 1; e.cyc = cyc;
    set_window(0, e);
    rx_line[0] = 1'b0;
    repeat (40 * bitclk[0]) @(negedge clk);
    check_eq("break_single_valid", got_q.size(), 1);
    expect_frame(e);
    idle_bits(0, 2);
    send_frame(0, 9'h055, 1'b0, 2'b11, -1, e); expect_frame(e);
    idle_bits(0, 6);

    // Short low glitch on idle line: false start, no frame, no eop
    eop_before = eop_cnt[0];
    rx_line[0] = 1'b0;
    repeat (6) @(negedge clk);
    idle_bits(0, 20);
    check_eq("glitch_no_valid", got_q.size(), 0);
    check_eq("glitch_no_eop", eop_cnt[0] - eop_before, 0);
    check_eq("glitch_idle", 32'(idle[0]), 1);
    send_frame(0, 9'h0C6, 1'b0, 2'b11, 3, e); expect_frame(e); idle_bits(0, 6);

    // Back-to-back burst then gap: one eop 32 ticks after the last frame
    eop_before = eop_cnt[0];
    send_frame(0, 9'h011, 1'b0, 2'b11, -1, e1);
    check_eq("idle_low_in_burst", 32'(idle[0]), 0);
    send_frame(0, 9'h022, 1'b0, 2'b11, -1, e2);
    send_frame(0, 9'h033, 1'b0, 2'b11, -1, e3);
    idle_bits(0, 6);
    expect_frame(e1); expect_frame(e2); expect_frame(e3);
    check_eq("burst_eop_count", eop_cnt[0] - eop_before, 1);
    check_eq("eop_delay", eop_cyc[0] - last_valid_cyc[0], 32);
    check_eq("idle_after_burst", 32'(idle[0]), 1);

    // Randomized frames across all three configurations
    for (int n = 0; n < 30; n++) begin
      logic [1:0] st;
      int         gl;
      li = $urandom_range(0, 2);
      st = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      gl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, dbits[li] - 1) : -1;
      send_frame(li, 9'($urandom), ($urandom_range(0, 3) == 0), st, gl, e);
      expect_frame(e);
      idle_bits(li, $urandom_range(1, 3));
    end

    // Reset in the middle of a frame: silent abort
    send_frame(0, 9'h03C, 1'b0, 2'b11, -1, e); expect_frame(e); idle_bits(0, 8);
    eop_before = eop_cnt[0];
    rx_line[0] = 1'b0;
    repeat (4 * bitclk[0]) @(negedge clk);
    resetn = 1'b0;
    rx_line[0] = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midreset_data", 32'(a_data), 0);
    check_eq("midreset_flags", {valid[0], perr[0], ferr[0], brk[0], eop[0]}, 0);
    check_eq("midreset_idle", 32'(idle[0]), 1);
    resetn = 1'b1;
    idle_bits(0, 20);
    check_eq("midreset_no_valid", got_q.size(), 0);
    check_eq("midreset_no_eop", eop_cnt[0] - eop_before, 0);
    check_eq("stray_break_or_eop", stray, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
